// File: rtl/ctrl_pkg.sv
// Shared definitions for the control sequencer: FSM states, control
// sub-codes, flag bit positions and the instruction field layout.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_WRITEBACK,
    ST_HALT
  } state_t;

  // op == OP_CTRL selects a control instruction; any other op is an ALU op
  localparam logic [2:0] OP_CTRL = 3'b000;

  // Control sub-codes carried in the rd field when op == OP_CTRL
  typedef enum logic [1:0] {
    CTL_NOP  = 2'b00,
    CTL_JMP  = 2'b01,
    CTL_JZ   = 2'b10,
    CTL_HALT = 2'b11
  } ctl_t;

  // Bit positions inside the stored {carry,sign,zero} flags
  localparam int unsigned FLAG_CARRY = 2;
  localparam int unsigned FLAG_SIGN  = 1;
  localparam int unsigned FLAG_ZERO  = 0;

  // Instruction word: [15:13] op, [12:11] rd, [10:9] rs, [8] imm_sel, [7:0] imm
  typedef struct packed {
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic       imm_sel;
    logic [7:0] imm;
  } instr_t;

endpackage

// File: rtl/regfile4x8.sv
// Four 8-bit registers: two combinational read ports, one synchronous
// write port, asynchronous active-low clear.
module regfile4x8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] ra_addr,
  output logic [7:0] ra_data,
  input  logic [1:0] rb_addr,
  output logic [7:0] rb_data,
  input  logic       we,
  input  logic [1:0] wa_addr,
  input  logic [7:0] wa_data
);

  logic [7:0] regs [4];

  // Storage: cleared by reset, written on the clock edge when we is set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
    end else if (we) begin
      regs[wa_addr] <= wa_data;
    end
  end

  // Read ports are purely combinational
  always_comb begin
    ra_data = regs[ra_addr];
    rb_data = regs[rb_addr];
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle instruction sequencer: fetches 16-bit words, drives an
// external registered ALU and writes its result back into a 4x8 register file.
module ctrl_sequencer
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  instr_addr,
  output logic        instr_rd,
  input  logic [15:0] instr_data,
  input  logic        instr_valid,
  output logic [7:0]  alu_o1,
  output logic [7:0]  alu_o2,
  output logic [2:0]  alu_opco,
  input  logic [7:0]  alu_result,
  input  logic        alu_carry,
  input  logic        alu_sign,
  input  logic        alu_zero,
  output logic        busy,
  output logic        halted,
  output logic [2:0]  flags
);

  state_t     state, state_nx;
  logic [7:0] pc, pc_nx;
  instr_t     ir, ir_nx;
  logic [2:0] flag_q, flag_nx;
  logic [7:0] rd_data, rs_data;
  logic       rf_we;

  regfile4x8 u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .ra_addr (ir.rd),
    .ra_data (rd_data),
    .rb_addr (ir.rs),
    .rb_data (rs_data),
    .we      (rf_we),
    .wa_addr (ir.rd),
    .wa_data (alu_result)
  );

  // State, PC, IR and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      pc     <= '0;
      ir     <= '0;
      flag_q <= '0;
    end else begin
      state  <= state_nx;
      pc     <= pc_nx;
      ir     <= ir_nx;
      flag_q <= flag_nx;
    end
  end

  // Next-state logic and per-state strobes
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    ir_nx    = ir;
    flag_nx  = flag_q;
    rf_we    = 1'b0;
    alu_opco = '0;
    instr_rd = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nx = ST_FETCH;
          pc_nx    = '0;
        end
      end
      ST_FETCH: begin
        instr_rd = 1'b1;
        if (instr_valid) begin
          ir_nx    = instr_data;
          state_nx = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (ir.op != OP_CTRL) begin
          state_nx = ST_EXECUTE;
        end else begin
          case (ctl_t'(ir.rd))
            CTL_NOP: begin
              pc_nx    = pc + 8'd1;
              state_nx = ST_FETCH;
            end
            CTL_JMP: begin
              pc_nx    = ir.imm;
              state_nx = ST_FETCH;
            end
            CTL_JZ: begin
              pc_nx    = flag_q[FLAG_ZERO] ? ir.imm : pc + 8'd1;
              state_nx = ST_FETCH;
            end
            CTL_HALT: begin
              state_nx = ST_HALT;
            end
          endcase
        end
      end
      ST_EXECUTE: begin
        alu_opco = ir.op;
        state_nx = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        rf_we    = 1'b1;
        flag_nx  = {alu_carry, alu_sign, alu_zero};
        pc_nx    = pc + 8'd1;
        state_nx = ST_FETCH;
      end
      ST_HALT: begin
        state_nx = ST_HALT;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Operands follow the IR and register file in every state so the registered
  // ALU still sees them while alu_opco is presented in EXECUTE; with IR and
  // registers cleared by reset they read as zero.
  always_comb begin
    instr_addr = pc;
    alu_o1     = rd_data;
    alu_o2     = ir.imm_sel ? ir.imm : rs_data;
    busy       = (state != ST_IDLE) && (state != ST_HALT);
    halted     = (state == ST_HALT);
    flags      = flag_q;
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: directed program table, hand-written
// reset/halt sequences and a random program checked against an ISA-level model.
module tb_ctrl_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, instr_rd, instr_valid;
  logic [7:0]  instr_addr, alu_o1, alu_o2, alu_result;
  logic [15:0] instr_data;
  logic [2:0]  alu_opco, flags;
  logic        alu_carry, alu_sign, alu_zero, busy, halted;

  ctrl_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .instr_addr  (instr_addr),
    .instr_rd    (instr_rd),
    .instr_data  (instr_data),
    .instr_valid (instr_valid),
    .alu_o1      (alu_o1),
    .alu_o2      (alu_o2),
    .alu_opco    (alu_opco),
    .alu_result  (alu_result),
    .alu_carry   (alu_carry),
    .alu_sign    (alu_sign),
    .alu_zero    (alu_zero),
    .busy        (busy),
    .halted      (halted),
    .flags       (flags)
  );

  always #5 clk = ~clk;

  int vec_count   = 0;
  int miscompares = 0;

  logic [15:0] mem [256];
  int fetch_delay = 0;
  int fetch_wait  = 0;
  bit start_noise = 0;

  // ISA-level reference state
  logic [7:0] m_pc;
  logic [7:0] m_r [4];
  logic [2:0] m_flags;
  bit         m_halt;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] instr;
    int          delay;
    logic [7:0]  nxt;
    logic [2:0]  flg;
    int          ridx;
    logic [7:0]  rval;
    int          cyc;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // External ALU behaviour: returns {carry, sign, zero, result}
  function automatic logic [10:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    case (op)
      3'd1:    s = {1'b0, a} + {1'b0, b};
      3'd2:    s = {1'b0, a} + {1'b0, ~b} + 9'd1;
      3'd3:    s = {1'b0, a & b};
      3'd4:    s = {1'b0, a | b};
      3'd5:    s = {1'b0, a ^ b};
      3'd6:    s = {a, 1'b0};
      default: s = {1'b0, b};
    endcase
    return {s[8], s[7], (s[7:0] == 8'h00), s[7:0]};
  endfunction

  task automatic model_reset();
    m_pc = 8'h00;
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_flags = 3'b000;
    m_halt  = 0;
  endtask

  task automatic model_exec(input logic [15:0] w, output int cyc);
    logic [2:0]  op;
    logic [1:0]  rd, rs;
    logic [7:0]  imm, b;
    logic [10:0] r;
    op  = w[15:13];
    rd  = w[12:11];
    rs  = w[10:9];
    imm = w[7:0];
    if (op != 3'b000) begin
      b = w[8] ? imm : m_r[rs];
      r = alu_fn(op, m_r[rd], b);
      m_r[rd] = r[7:0];
      m_flags = r[10:8];
      m_pc    = m_pc + 8'd1;
      cyc     = 4;
    end else begin
      cyc = 2;
      case (rd)
        2'd0:    m_pc = m_pc + 8'd1;
        2'd1:    m_pc = imm;
        2'd2:    m_pc = m_flags[0] ? imm : m_pc + 8'd1;
        default: m_halt = 1;
      endcase
    end
  endtask

  // One clock: memory and ALU responses, then settle 1 time unit past the edge
  task automatic tick();
    logic [2:0]  op;
    logic [7:0]  a, b;
    if (instr_rd === 1'b1) begin
      instr_valid = (fetch_wait >= fetch_delay);
      instr_data  = instr_valid ? mem[instr_addr] : 16'($urandom);
      fetch_wait++;
    end else begin
      instr_valid = 1'b0;
      instr_data  = 16'($urandom);
      fetch_wait  = 0;
    end
    if (start_noise) start = 1'($urandom_range(0, 1));
    op = alu_opco;
    a  = alu_o1;
    b  = alu_o2;
    @(posedge clk);
    #1;
    if (op != 3'b000) {alu_carry, alu_sign, alu_zero, alu_result} = alu_fn(op, a, b);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_to_fetch", instr_rd, 1);
  endtask

  // Run one instruction from the first FETCH cycle to the next FETCH (or HALT)
  task automatic run_instr(input int delay, output int cyc, output int exp_cyc);
    logic [15:0] w;
    logic [7:0]  pc0, e_o1, e_o2;
    bit          done;
    chk("fetch_rd", instr_rd, 1);
    chk("fetch_addr", instr_addr, m_pc);
    pc0  = m_pc;
    w    = mem[m_pc];
    e_o1 = m_r[w[12:11]];
    e_o2 = w[8] ? w[7:0] : m_r[w[10:9]];
    fetch_delay = delay;
    model_exec(w, exp_cyc);
    exp_cyc += delay;
    cyc  = 0;
    done = 0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
      if (cyc <= delay) begin
        chk("wait_rd", instr_rd, 1);
        chk("wait_addr", instr_addr, pc0);
      end else if (cyc == delay + 1) begin
        chk("decode_o1", alu_o1, e_o1);
        chk("decode_o2", alu_o2, e_o2);
        chk("decode_opco", alu_opco, 0);
      end else if (cyc == delay + 2 && w[15:13] != 3'b000) begin
        chk("exec_opco", alu_opco, w[15:13]);
      end else if (cyc == delay + 3 && w[15:13] != 3'b000) begin
        chk("wb_opco", alu_opco, 0);
      end
      if (cyc > delay && (instr_rd === 1'b1 || halted === 1'b1)) done = 1;
    end
  endtask

  task automatic check_model();
    chk("model_halted", halted, m_halt);
    chk("model_busy", busy, !m_halt);
    if (!m_halt) chk("model_next_addr", instr_addr, m_pc);
    chk("model_flags", flags, m_flags);
    for (int i = 0; i < 4; i++) chk("model_reg", dut.u_regfile.regs[i], m_r[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, e;
    rst_n = 1'b0; start = 1'b0; instr_valid = 1'b0; instr_data = '0;
    alu_result = '0; alu_carry = 1'b0; alu_sign = 1'b0; alu_zero = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    model_reset();

    tbl[0] = '{8'h00, 16'hE905, 0, 8'h01, 3'b000, 1, 8'h05, 4}; // MOV R1,#05
    tbl[1] = '{8'h01, 16'hF1FB, 0, 8'h02, 3'b010, 2, 8'hFB, 4}; // MOV R2,#FB
    tbl[2] = '{8'h02, 16'h2C00, 0, 8'h03, 3'b101, 1, 8'h00, 4}; // ADD R1,R2
    tbl[3] = '{8'h03, 16'h1020, 0, 8'h20, 3'b101, 1, 8'h00, 2}; // JZ #20 taken
    tbl[4] = '{8'h20, 16'hE103, 1, 8'h21, 3'b000, 0, 8'h03, 5}; // MOV R0,#03
    tbl[5] = '{8'h21, 16'h4105, 3, 8'h22, 3'b010, 0, 8'hFE, 7}; // SUB R0,#05
    tbl[6] = '{8'h22, 16'h1040, 0, 8'h23, 3'b010, 0, 8'hFE, 2}; // JZ #40 not taken
    tbl[7] = '{8'h23, 16'h08FF, 2, 8'hFF, 3'b010, 2, 8'hFB, 4}; // JMP #FF
    tbl[8] = '{8'hFF, 16'h0000, 0, 8'h00, 3'b010, 1, 8'h00, 2}; // NOP wraps

    // Reset state
    @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_instr_rd", instr_rd, 0);
    chk("rst_addr", instr_addr, 0);
    chk("rst_opco", alu_opco, 0);
    chk("rst_flags", flags, 0);
    chk("rst_o1", alu_o1, 0);
    chk("rst_o2", alu_o2, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_start", busy, 0);

    // Directed program from the table
    for (int i = 0; i < 9; i++) mem[tbl[i].addr] = tbl[i].instr;
    do_start();
    for (int i = 0; i < 9; i++) begin
      chk("tbl_addr", instr_addr, tbl[i].addr);
      run_instr(tbl[i].delay, c, e);
      chk("tbl_cycles", c, tbl[i].cyc);
      chk("tbl_next_addr", instr_addr, tbl[i].nxt);
      chk("tbl_flags", flags, tbl[i].flg);
      chk("tbl_reg", dut.u_regfile.regs[tbl[i].ridx], tbl[i].rval);
    end

    // Reset pulsed during EXECUTE of MOV R1,#05 at 0x00
    fetch_delay = 0;
    tick();
    tick();
    chk("mid_exec_opco", alu_opco, 3'b111);
    chk("mid_exec_busy", busy, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_instr_rd", instr_rd, 0);
    chk("async_addr", instr_addr, 0);
    chk("async_opco", alu_opco, 0);
    chk("async_flags", flags, 0);
    for (int i = 0; i < 4; i++) chk("async_reg", dut.u_regfile.regs[i], 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", busy, 0);
    chk("post_rst_no_write", dut.u_regfile.regs[1], 0);
    model_reset();

    // HALT, then start pulses are ignored until reset
    mem[0] = 16'h1800;
    do_start();
    run_instr(0, c, e);
    chk("halt_cycles", c, 2);
    chk("halt_halted", halted, 1);
    chk("halt_busy", busy, 0);
    for (int i = 0; i < 6; i++) begin
      start = ~start;
      tick();
      chk("halt_hold", halted, 1);
      chk("halt_hold_rd", instr_rd, 0);
    end
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("halt_reset", halted, 0);
    tick();
    rst_n = 1'b1;
    model_reset();

    // Random program (no HALT) against the reference model
    for (int i = 0; i < 256; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (w[15:13] == 3'b000 && w[12:11] == 2'b11) w[12:11] = 2'b00;
      mem[i] = w;
    end
    do_start();
    start_noise = 1;
    for (int n = 0; n < 150; n++) begin
      run_instr($urandom_range(0, 3), c, e);
      chk("rand_cycles", c, e);
      check_model();
    end
    start_noise = 0;
    start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
CTRL_SEQUENCER -- requirements
Module: ctrl_sequencer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  system clock; all state updates on posedge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse; begins execution from PC 0x00 when in IDLE.
REQ-005 instr_addr  output  8  instruction memory address, equal to PC.
REQ-006 instr_rd  output  1  instruction read request, asserted throughout FETCH.
REQ-007 instr_data  input  16  instruction word, valid when instr_valid=1.
REQ-008 instr_valid  input  1  memory acknowledge; sampled only while instr_rd=1.
REQ-009 alu_o1, alu_o2  output  8 each  ALU operands.
REQ-010 alu_opco  output  3  ALU opcode; 000 means no operation.
REQ-011 alu_result  input  8  ALU registered result.
REQ-012 alu_carry, alu_sign, alu_zero  input  1 each  ALU registered flags.
REQ-013 busy  output  1  high in every state except IDLE and HALT.
REQ-014 halted  output  1  high in HALT.
REQ-015 flags  output  3  stored {carry,sign,zero}.

Function
REQ-016 Instruction format SHALL be: [15:13] op, [12:11] rd, [10:9] rs, [8] imm_sel, [7:0] imm.
REQ-017 op 001..111 SHALL be ALU instructions; op 000 SHALL be control, selected by [12:11]: 00 NOP, 01 JMP imm, 10 JZ imm (taken when stored zero=1), 11 HALT.
REQ-018 States SHALL be IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
REQ-019 IDLE->FETCH on start=1, with PC set to 0x00; start in any other state SHALL be ignored.
REQ-020 FETCH SHALL hold instr_rd=1 and instr_addr stable until instr_valid=1; on instr_valid=1 it SHALL latch instr_data into the IR and go to DECODE.
REQ-021 DECODE SHALL drive alu_o1=R[rd] and alu_o2=(imm_sel ? imm : R[rs]).
REQ-022 DECODE for an ALU op SHALL go to EXECUTE.
REQ-023 DECODE for NOP and for JZ not taken SHALL set PC=PC+1 and go to FETCH.
REQ-024 DECODE for JMP and for JZ taken SHALL set PC=imm and go to FETCH.
REQ-025 DECODE for HALT SHALL go to HALT.
REQ-026 EXECUTE SHALL drive alu_opco=op for exactly one cycle, then go to WRITEBACK; alu_opco SHALL be 000 in all other states.
REQ-027 WRITEBACK SHALL write alu_result into R[rd], capture {alu_carry,alu_sign,alu_zero} into flags, set PC=PC+1 and go to FETCH.
REQ-028 Flags SHALL change only in WRITEBACK.
REQ-029 PC arithmetic SHALL be 8-bit modulo: 0xFF+1 -> 0x00.
REQ-030 ALU instruction latency SHALL be 4 cycles when instr_valid is high on the first FETCH cycle; control instructions SHALL take 2 cycles.
REQ-031 HALT SHALL be left only by reset.

Reset
REQ-032 rst_n=0 SHALL, at any time and in any state, immediately force: state IDLE, PC=0x00, IR=0, R0..R3=0x00, flags=000, all outputs 0.
REQ-033 Reset asserted mid-instruction SHALL discard that instruction with no register-file write.

Structure
REQ-034 Opcode constants, control sub-codes, state encoding and instruction field positions SHALL reside in the shared package ctrl_pkg.
REQ-035 The 4x8 register file SHALL be the sub-module regfile4x8: two combinational read ports, one synchronous write port, async active-low clear.

Verification
REQ-036 Program MOV R1,#05; MOV R2,#FB; ADD R1,R2 (op 111, 111, 001) -> R1=0x00, flags={1,0,1}, 4 cycles per instruction.
REQ-037 After REQ-036, JZ #20 -> next instr_addr=0x20; with zero=0 -> next instr_addr=PC+1.
REQ-038 MOV R0,#03; SUB R0,#05 -> R0=0xFE, sign=1, carry=0, zero=0.
REQ-039 instr_valid delayed 3 cycles in FETCH -> instr_rd stays 1, instr_addr unchanged, no state advance.
REQ-040 NOP at 0xFF -> next fetch at 0x00; rst_n pulsed low in EXECUTE -> state IDLE, busy=0, registers 0x00, no write.
REQ-041 HALT -> halted=1, busy=0, start pulses ignored until rst_n low.
